bank_wr_sched: RTL and testbench

BANK_WR_SCHED -- requirements
Module: bank_wr_sched

---
 rtl/bank_wr_sched_pkg.sv | 33 +++
 rtl/bank_rd_gate.sv | 58 +++++
 rtl/bank_wr_sched.sv | 143 ++++++++++++++
 tb/tb_bank_wr_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_wr_sched_pkg.sv
// Shared constants and FSM encoding for the reference-buffer bank write scheduler,
// its read gate, the banks and the ME top.
package bank_wr_sched_pkg;

    localparam int NUM_BANK    = 4;
    localparam int SEG_LEN     = 24;
    localparam int DEPTH       = 96;
    localparam int ADDR_W      = 7;
    localparam int MAX_ROUNDS  = 4;

    localparam int BANK_W      = $clog2(NUM_BANK);
    localparam int SEG_W       = $clog2(SEG_LEN);
    localparam int ROUND_BEATS = NUM_BANK * SEG_LEN;
    localparam int JOB_W       = $clog2(MAX_ROUNDS * ROUND_BEATS);

    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [SEG_W-1:0]  SEG_LAST = SEG_W'(SEG_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIN  = 2'd2
    } wr_state_e;

    function automatic logic [NUM_BANK-1:0] bank_onehot(input logic [BANK_W-1:0] b);
        return NUM_BANK'(1) << b;
    endfunction

    function automatic logic rounds_legal(input logic [2:0] r);
        return (r != 3'd0) && (r <= 3'(MAX_ROUNDS));
    endfunction

endpackage

// File: rtl/bank_rd_gate.sv
// Read admission for the reference banks: a read is granted only for an address
// that is in range and already written (or the bank has wrapped at least once).
module bank_rd_gate
    import bank_wr_sched_pkg::*;
(
    input  logic                             clk,
    input  logic                             i_srst,
    input  logic                             i_rd_req,
    input  logic [BANK_W-1:0]                i_rd_bank,
    input  logic [ADDR_W-1:0]                i_rd_addr,
    input  logic [NUM_BANK-1:0][ADDR_W-1:0]  i_wr_ptr,
    input  logic [NUM_BANK-1:0]              i_filled,
    output logic                             o_rd_grant,
    output logic [NUM_BANK-1:0]              o_rd_en,
    output logic [ADDR_W-1:0]                o_address,
    output logic                             o_rd_valid,
    output logic                             o_rd_err
);

    logic w_in_range;
    logic w_written;

    logic [NUM_BANK-1:0] r_rd_en;
    logic [ADDR_W-1:0]   r_address;
    logic                r_vld_d1;
    logic                r_rd_valid;
    logic                r_rd_err;

    // wr_ptr only counts beats that have already landed in the bank, so a beat
    // being written this cycle is not yet readable.
    assign w_in_range = i_rd_addr < DEPTH_A;
    assign w_written  = i_filled[i_rd_bank] | (i_rd_addr < i_wr_ptr[i_rd_bank]);
    assign o_rd_grant = i_rd_req & w_in_range & w_written;

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_rd_en    <= '0;
            r_address  <= '0;
            r_vld_d1   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_en    <= o_rd_grant ? bank_onehot(i_rd_bank) : '0;
            if (o_rd_grant) begin
                r_address <= i_rd_addr;
            end
            r_vld_d1   <= o_rd_grant;
            r_rd_valid <= r_vld_d1;
            r_rd_err   <= i_rd_req & ~w_in_range;
        end
    end

    assign o_rd_en    = r_rd_en;
    assign o_address  = r_address;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_err   = r_rd_err;

endmodule

// File: rtl/bank_wr_sched.sv
// Round-robin write scheduler filling NUM_BANK reference banks SEG_LEN beats at a
// time, with per-bank shadow write pointers feeding the read gate.
module bank_wr_sched
    import bank_wr_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           cfg_rounds,
    input  logic                 in_valid,
    input  logic [63:0]          in_data,
    output logic                 in_ready,
    output logic                 beg_en,
    output logic [63:0]          ref_in,
    output logic [NUM_BANK-1:0]  bank_sel,
    input  logic                 rd_req,
    input  logic [BANK_W-1:0]    rd_bank,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic                 rd_grant,
    output logic [NUM_BANK-1:0]  rd_en,
    output logic [ADDR_W-1:0]    address,
    output logic                 rd_valid,
    output logic                 rd_err,
    output logic                 done
);

    wr_state_e r_state;
    wr_state_e w_state_next;

    logic [2:0]                      r_rounds;
    logic [JOB_W-1:0]                r_job_cnt;
    logic [SEG_W-1:0]                r_seg_cnt;
    logic [BANK_W-1:0]               r_cur_bank;
    logic [NUM_BANK-1:0][ADDR_W-1:0] r_wr_ptr;
    logic [NUM_BANK-1:0]             r_filled;
    logic                            r_beg_en;
    logic [63:0]                     r_ref_in;
    logic [NUM_BANK-1:0]             r_bank_sel;
    logic                            r_done;

    logic             w_xfer;
    logic             w_load_job;
    logic             w_last;
    logic [JOB_W-1:0] w_job_last;

    assign in_ready   = (r_state == ST_LOAD);
    assign w_xfer     = in_valid & in_ready;
    assign w_load_job = (r_state == ST_IDLE) & start & rounds_legal(cfg_rounds);
    assign w_job_last = JOB_W'(r_rounds) * JOB_W'(ROUND_BEATS) - JOB_W'(1);
    assign w_last     = w_xfer & (r_job_cnt == w_job_last);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_load_job) w_state_next = ST_LOAD;
            ST_LOAD: if (w_last)     w_state_next = ST_FIN;
            ST_FIN:                  w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= ST_IDLE;
            r_rounds  <= '0;
            r_job_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == ST_FIN);
            if (w_load_job) begin
                r_rounds  <= cfg_rounds;
                r_job_cnt <= '0;
            end else if (w_xfer) begin
                r_job_cnt <= w_last ? '0 : r_job_cnt + JOB_W'(1);
            end
        end
    end

    // Segment position and current bank persist across jobs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_seg_cnt  <= '0;
            r_cur_bank <= '0;
            r_beg_en   <= 1'b0;
            r_ref_in   <= '0;
            r_bank_sel <= '0;
        end else begin
            r_beg_en   <= w_xfer;
            r_bank_sel <= w_xfer ? bank_onehot(r_cur_bank) : '0;
            if (w_xfer) begin
                r_ref_in <= in_data;
                if (r_seg_cnt == SEG_LAST) begin
                    r_seg_cnt  <= '0;
                    r_cur_bank <= (r_cur_bank == BANK_W'(NUM_BANK - 1)) ? '0
                                                                       : r_cur_bank + BANK_W'(1);
                end else begin
                    r_seg_cnt <= r_seg_cnt + SEG_W'(1);
                end
            end
        end
    end

    // Shadow pointers advance when the registered write strobe reaches the bank.
    generate
        for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank_ptr
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    r_wr_ptr[gi] <= '0;
                    r_filled[gi] <= 1'b0;
                end else if (r_beg_en && r_bank_sel[gi]) begin
                    if (r_wr_ptr[gi] == DEPTH_A - ADDR_W'(1)) begin
                        r_wr_ptr[gi] <= '0;
                        r_filled[gi] <= 1'b1;
                    end else begin
                        r_wr_ptr[gi] <= r_wr_ptr[gi] + ADDR_W'(1);
                    end
                end
            end
        end
    endgenerate

    bank_rd_gate u_rd_gate (
        .clk        (clk),
        .i_srst     (rst_n),
        .i_rd_req   (rd_req),
        .i_rd_bank  (rd_bank),
        .i_rd_addr  (rd_addr),
        .i_wr_ptr   (r_wr_ptr),
        .i_filled   (r_filled),
        .o_rd_grant (rd_grant),
        .o_rd_en    (rd_en),
        .o_address  (address),
        .o_rd_valid (rd_valid),
        .o_rd_err   (rd_err)
    );

    assign beg_en   = r_beg_en;
    assign ref_in   = r_ref_in;
    assign bank_sel = r_bank_sel;
    assign done     = r_done;

endmodule

// File: tb/tb_bank_wr_sched.sv
// Directed bench for bank_wr_sched: write-job scenarios with a beat model plus a
// table of read-gate vectors and hand-written bypass/reset sequences.
module tb_bank_wr_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  cfg_rounds;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        beg_en;
    logic [63:0] ref_in;
    logic [3:0]  bank_sel;
    logic        rd_req;
    logic [1:0]  rd_bank;
    logic [6:0]  rd_addr;
    logic        rd_grant;
    logic [3:0]  rd_en;
    logic [6:0]  address;
    logic        rd_valid;
    logic        rd_err;
    logic        done;

    int nchk = 0;
    int nbad = 0;
    int m_seg = 0;
    int m_bank = 0;

    typedef struct {
        logic [1:0] bank;
        logic [6:0] addr;
        logic       grant;
        logic       err;
    } rd_vec_t;

    rd_vec_t vt[10];

    bank_wr_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_rounds (cfg_rounds),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .beg_en     (beg_en),
        .ref_in     (ref_in),
        .bank_sel   (bank_sel),
        .rd_req     (rd_req),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .rd_grant   (rd_grant),
        .rd_en      (rd_en),
        .address    (address),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".in_ready"}, in_ready, 0);
        chk({nm, ".beg_en"},   beg_en,   0);
        chk({nm, ".bank_sel"}, bank_sel, 0);
        chk({nm, ".ref_in"},   ref_in,   0);
        chk({nm, ".rd_en"},    rd_en,    0);
        chk({nm, ".rd_valid"}, rd_valid, 0);
        chk({nm, ".rd_err"},   rd_err,   0);
        chk({nm, ".address"},  address,  0);
        chk({nm, ".done"},     done,     0);
    endtask

    task automatic rd_case(input string nm, input logic [1:0] bank, input logic [6:0] addr,
                           input logic g, input logic e);
        logic [3:0] one;
        one     = 4'b0001 << bank;
        rd_req  = 1'b1;
        rd_bank = bank;
        rd_addr = addr;
        #1;
        chk({nm, ".grant"}, rd_grant, g);
        tick;
        rd_req = 1'b0;
        chk({nm, ".rd_en"}, rd_en, g ? one : 4'b0000);
        if (g) chk({nm, ".address"}, address, addr);
        chk({nm, ".rd_err"}, rd_err, e);
        chk({nm, ".rd_valid_early"}, rd_valid, 0);
        tick;
        chk({nm, ".rd_valid"}, rd_valid, g);
        chk({nm, ".rd_en_clr"}, rd_en, 0);
        chk({nm, ".rd_err_clr"}, rd_err, 0);
        $display("rd %s bank=%0d addr=%0d grant=%0b err=%0b", nm, bank, addr, g, e);
    endtask

    task automatic run_job(input int rounds, input bit toggle, input bit poke_start,
                           output logic [3:0] first_sel);
        int cyc, beats, pulses, dones, done_cyc, budget;
        bit pend;
        logic [63:0] exp_d;
        logic [3:0]  exp_sel;
        cyc = 0; beats = 0; pulses = 0; dones = 0; done_cyc = -1; pend = 0;
        exp_d = '0; exp_sel = '0; first_sel = '0;
        budget = rounds * 96 * 2 + 20;
        cfg_rounds = 3'(rounds);
        in_valid = 1'b0;
        start = 1'b1;
        while (dones == 0 && cyc < budget) begin
            tick;
            cyc++;
            start = poke_start && (cyc == 40);
            if (pend) begin
                chk("job.beg_en", beg_en, 1);
                chk("job.bank_sel", bank_sel, exp_sel);
                chk("job.ref_in", ref_in, exp_d);
                pulses++;
                if (first_sel == 4'b0000) first_sel = bank_sel;
            end else begin
                chk("job.beg_en_idle", beg_en, 0);
                chk("job.bank_sel_idle", bank_sel, 0);
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            in_valid = toggle ? (cyc % 2 == 1) : 1'b1;
            in_data  = {32'(cyc) * 32'h9E37_79B9, 32'(beats) ^ 32'hA5A5_0000};
            pend = in_ready && in_valid;
            if (pend) begin
                exp_d   = in_data;
                exp_sel = 4'(1 << m_bank);
                beats++;
                m_seg++;
                if (m_seg == 24) begin
                    m_seg  = 0;
                    m_bank = (m_bank + 1) % 4;
                end
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk("job.done_seen", dones, 1);
        chk("job.beats", beats, rounds * 96);
        chk("job.beg_pulses", pulses, rounds * 96);
        if (!toggle) chk("job.done_cycle", done_cyc, rounds * 96 + 2);
        tick;
        chk("job.done_one_pulse", done, 0);
        chk("job.idle_ready", in_ready, 0);
        $display("job rounds=%0d toggle=%0b beats=%0d done_cycle=%0d", rounds, toggle, beats, done_cyc);
    endtask

    initial begin
        logic [3:0] fsel;
        vt[0] = '{2'd0, 7'd0,   1'b1, 1'b0};
        vt[1] = '{2'd1, 7'd23,  1'b1, 1'b0};
        vt[2] = '{2'd2, 7'd24,  1'b0, 1'b0};
        vt[3] = '{2'd3, 7'd95,  1'b0, 1'b0};
        vt[4] = '{2'd0, 7'd100, 1'b0, 1'b1};
        vt[5] = '{2'd3, 7'd127, 1'b0, 1'b1};
        vt[6] = '{2'd1, 7'd96,  1'b0, 1'b1};
        vt[7] = '{2'd2, 7'd95,  1'b1, 1'b0};
        vt[8] = '{2'd0, 7'd50,  1'b1, 1'b0};
        vt[9] = '{2'd3, 7'd96,  1'b0, 1'b1};

        rst_n = 1'b1; start = 1'b0; cfg_rounds = 3'd0; in_valid = 1'b0; in_data = '0;
        rd_req = 1'b0; rd_bank = '0; rd_addr = '0;
        repeat (3) tick;
        chk_all_zero("reset");
        rst_n = 1'b0;
        tick;
        $display("reset released");

        // Illegal round counts must not leave IDLE.
        cfg_rounds = 3'd0; start = 1'b1; tick; start = 1'b0;
        chk("ill0.in_ready", in_ready, 0); tick; chk("ill0.in_ready2", in_ready, 0);
        cfg_rounds = 3'd5; start = 1'b1; tick; start = 1'b0;
        chk("ill5.in_ready", in_ready, 0); tick; chk("ill5.in_ready2", in_ready, 0);
        $display("illegal starts ignored check done");

        run_job(1, 1'b0, 1'b0, fsel);
        chk("job1.first_sel", fsel, 4'b0001);
        for (int i = 0; i < 7; i++)
            rd_case($sformatf("vec%0d", i), vt[i].bank, vt[i].addr, vt[i].grant, vt[i].err);

        run_job(1, 1'b1, 1'b1, fsel);
        run_job(4, 1'b0, 1'b0, fsel);
        run_job(4, 1'b0, 1'b0, fsel);
        chk("job4b.first_sel", fsel, 4'b0001);
        for (int i = 7; i < 10; i++)
            rd_case($sformatf("vec%0d", i), vt[i].bank, vt[i].addr, vt[i].grant, vt[i].err);

        // Reset at beat 50 with a read in flight.
        cfg_rounds = 3'd1; start = 1'b1; tick; start = 1'b0;
        in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001;
        repeat (50) tick;
        rd_req = 1'b1; rd_bank = 2'd0; rd_addr = 7'd0;
        tick;
        rd_req = 1'b0; rst_n = 1'b1;
        chk("rst50.rd_en_before", rd_en, 4'b0001);
        tick;
        chk_all_zero("rst50");
        rst_n = 1'b0; in_valid = 1'b0;
        m_seg = 0; m_bank = 0;
        tick;
        chk("rst50.rd_valid_cancel", rd_valid, 0);
        rd_req = 1'b1; #1;
        chk("rst50.filled_clr", rd_grant, 0);
        rd_req = 1'b0;
        repeat (3) begin tick; chk("rst50.no_done", done, 0); end
        $display("reset at beat 50 done");

        // New job after reset: 24 beats to bank 0, 5 to bank 1.
        cfg_rounds = 3'd1; start = 1'b1; tick; start = 1'b0;
        in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF;
        tick;
        tick;
        chk("new.first_beg", beg_en, 1);
        chk("new.first_sel", bank_sel, 4'b0001);
        repeat (27) tick;
        in_valid = 1'b0;
        repeat (2) tick;
        rd_case("new.b0a0", 2'd0, 7'd0, 1'b1, 1'b0);
        rd_case("new.b0a23", 2'd0, 7'd23, 1'b1, 1'b0);
        rd_case("byp.b1a4", 2'd1, 7'd4, 1'b1, 1'b0);

        // Address 5 of bank 1 stays blocked until the 6th beat lands.
        rd_req = 1'b1; rd_bank = 2'd1; rd_addr = 7'd5; #1;
        chk("byp.a5_wait", rd_grant, 0);
        tick;
        chk("byp.a5_rd_en", rd_en, 0);
        in_valid = 1'b1; in_data = 64'h6666_0000_0000_0006; #1;
        chk("byp.a5_before", rd_grant, 0);
        tick;
        in_valid = 1'b0;
        chk("byp.beat6_beg", beg_en, 1);
        chk("byp.beat6_sel", bank_sel, 4'b0010);
        chk("byp.same_cycle", rd_grant, 0);
        tick;
        chk("byp.after_land", rd_grant, 1);
        tick;
        rd_req = 1'b0;
        chk("byp.rd_en", rd_en, 4'b0010);
        chk("byp.address", address, 7'd5);
        tick;
        chk("byp.rd_valid", rd_valid, 1);
        $display("bypass sequence done");

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
